// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports, two write lanes, issue strobe and busy vector.
// The master drives addresses, write data and issue strobes; the register file is the slave.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  localparam int NREG = 1 << AW;

  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            rd1_busy;
  logic            rd2_busy;
  logic            we1;
  logic [AW-1:0]   wa1;
  logic [XLEN-1:0] wd1;
  logic            we2;
  logic [AW-1:0]   wa2;
  logic [XLEN-1:0] wd2;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic [NREG-1:0] busy_vec;

  modport master (
    output ra1, ra2, we1, wa1, wd1, we2, wa2, wd2, iss_en, iss_addr,
    input  rd1, rd2, rd1_busy, rd2_busy, busy_vec
  );

  modport slave (
    input  ra1, ra2, we1, wa1, wd1, we2, wa2, wd2, iss_en, iss_addr,
    output rd1, rd2, rd1_busy, rd2_busy, busy_vec
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, two write lanes and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  rf
);
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            busy;
  } rd_t;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  rd_t             p1;
  rd_t             p2;

  // False only for register 0 when it is hardwired to zero.
  function automatic logic writable(input logic [AW-1:0] a);
    return !(ZERO_REG != 0 && a == '0);
  endfunction

  function automatic rd_t read_port(input logic [AW-1:0] a);
    rd_t r;
    r.data = regs[a];
    r.busy = busy[a];
`ifdef REGFILE_BYPASS_EN
    // Lane 2 is checked last so it wins when both lanes target the same address.
    if (rf.we1 && rf.wa1 == a) begin
      r.data = rf.wd1;
      r.busy = rf.iss_en && rf.iss_addr == a;
    end
    if (rf.we2 && rf.wa2 == a) begin
      r.data = rf.wd2;
      r.busy = rf.iss_en && rf.iss_addr == a;
    end
`endif
    if (!writable(a)) r = '0;
    return r;
  endfunction

  // Clears from writeback first, then the issue set, so a same-edge issue leaves the bit set.
  always_comb begin
    // NOTE: default assigned first so no path through this block can infer a latch.
    busy_nxt = busy;
    if (rf.we1 && writable(rf.wa1)) busy_nxt[rf.wa1] = 1'b0;
    if (rf.we2 && writable(rf.wa2)) busy_nxt[rf.wa2] = 1'b0;
    if (rf.iss_en && writable(rf.iss_addr)) busy_nxt[rf.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data array is reset because the pipeline expects all-zero operands after reset.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      // Later non-blocking write takes effect, giving lane 2 priority on an address collision.
      if (rf.we1 && writable(rf.wa1)) regs[rf.wa1] <= rf.wd1;
      if (rf.we2 && writable(rf.wa2)) regs[rf.wa2] <= rf.wd2;
    end
  end

  always_comb begin
    p1 = read_port(rf.ra1);
    p2 = read_port(rf.ra2);
  end

  assign rf.rd1      = p1.data;
  assign rf.rd1_busy = p1.busy;
  assign rf.rd2      = p2.data;
  assign rf.rd2_busy = p2.busy;
  assign rf.busy_vec = busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected read-port values, a negedge monitor checks them.
// Expectations for same-cycle forwarding follow REGFILE_BYPASS_EN.
module tb_regfile_sb;
  typedef enum int {K_RD1, K_RD2, K_B1, K_B2, K_BV} kind_t;

  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  regfile_sb_if #(.XLEN(32), .AW(5)) bus ();

  regfile_sb #(.XLEN(32), .AW(5), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so every queued expectation is checked on the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        K_RD1:   act = bus.rd1;
        K_RD2:   act = bus.rd2;
        K_B1:    act = {31'd0, bus.rd1_busy};
        K_B2:    act = {31'd0, bus.rd2_busy};
        default: act = bus.busy_vec;
      endcase
      check(e.name, act, e.val);
    end
  end

  task automatic expect_v(input string name, input kind_t kind, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    rst          = 1'b0;
    bus.we1      = 1'b0;
    bus.wa1      = '0;
    bus.wd1      = '0;
    bus.we2      = 1'b0;
    bus.wa2      = '0;
    bus.wd2      = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst     = 1'b1;
    bus.ra1 = '0;
    bus.ra2 = '0;
    cycle();

    // Reset state
    idle();
    bus.ra1 = 5'd3;
    bus.ra2 = 5'd31;
    expect_v("rst_rd1", K_RD1, 32'h0);
    expect_v("rst_rd2", K_RD2, 32'h0);
    expect_v("rst_b1",  K_B1,  32'h0);
    expect_v("rst_b2",  K_B2,  32'h0);
    expect_v("rst_bv",  K_BV,  32'h0);
    cycle();

    // Reset overrides a write on the same edge
    rst = 1'b1; bus.we1 = 1'b1; bus.wa1 = 5'd3; bus.wd1 = 32'hAAAA_5555;
    cycle();
    idle();
    expect_v("rst_beats_wr", K_RD1, 32'h0);
    cycle();

    // Both lanes to address 5: lane 2 wins
    bus.we1 = 1'b1; bus.wa1 = 5'd5; bus.wd1 = 32'h11;
    bus.we2 = 1'b1; bus.wa2 = 5'd5; bus.wd2 = 32'h22;
    cycle();
    idle();
    bus.ra1 = 5'd5;
    expect_v("lane2_wins", K_RD1, 32'h22);
    cycle();

    // Issue marks busy, writeback clears it
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    cycle();
    idle();
    bus.ra1 = 5'd7;
    expect_v("iss7_b1", K_B1, 32'h1);
    expect_v("iss7_bv", K_BV, 32'h0000_0080);
    cycle();
    bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h99;
    cycle();
    idle();
    expect_v("wb7_rd1", K_RD1, 32'h99);
    expect_v("wb7_b1",  K_B1,  32'h0);
    expect_v("wb7_bv",  K_BV,  32'h0);
    cycle();

    // Issue and write on the same edge: issue wins for busy
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    bus.we2 = 1'b1; bus.wa2 = 5'd9; bus.wd2 = 32'h44;
    cycle();
    idle();
    bus.ra2 = 5'd9;
    expect_v("iss_wr9_rd2", K_RD2, 32'h44);
    expect_v("iss_wr9_b2",  K_B2,  32'h1);
    expect_v("iss_wr9_bv",  K_BV,  32'h0000_0200);
    cycle();

    // Register 0 ignores writes and issues, including during the writing cycle
    bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
    bus.we1 = 1'b1; bus.wa1 = 5'd0; bus.wd1 = 32'hFFFF_FFFF;
    bus.ra1 = 5'd0;
    expect_v("r0_same_rd1", K_RD1, 32'h0);
    expect_v("r0_same_b1",  K_B1,  32'h0);
    cycle();
    idle();
    expect_v("r0_rd1", K_RD1, 32'h0);
    expect_v("r0_b1",  K_B1,  32'h0);
    expect_v("r0_bv",  K_BV,  32'h0000_0200);
    cycle();

    // Write to a busy register while reading it in the same cycle
    bus.iss_en = 1'b1; bus.iss_addr = 5'd12;
    cycle();
    idle();
    bus.we1 = 1'b1; bus.wa1 = 5'd12; bus.wd1 = 32'hCAFE;
    bus.ra2 = 5'd12;
`ifdef REGFILE_BYPASS_EN
    expect_v("fwd12_rd2", K_RD2, 32'hCAFE);
    expect_v("fwd12_b2",  K_B2,  32'h0);
`else
    expect_v("fwd12_rd2", K_RD2, 32'h0);
    expect_v("fwd12_b2",  K_B2,  32'h1);
`endif
    expect_v("fwd12_bv", K_BV, 32'h0000_1200);
    cycle();
    idle();
    expect_v("post12_rd2", K_RD2, 32'hCAFE);
    expect_v("post12_b2",  K_B2,  32'h0);
    expect_v("post12_bv",  K_BV,  32'h0000_0200);
    cycle();

    // Same-cycle issue and write to a non-busy register being read
    bus.iss_en = 1'b1; bus.iss_addr = 5'd13;
    bus.we1 = 1'b1; bus.wa1 = 5'd13; bus.wd1 = 32'h5;
    bus.ra1 = 5'd13;
`ifdef REGFILE_BYPASS_EN
    expect_v("fwd13_rd1", K_RD1, 32'h5);
    expect_v("fwd13_b1",  K_B1,  32'h1);
`else
    expect_v("fwd13_rd1", K_RD1, 32'h0);
    expect_v("fwd13_b1",  K_B1,  32'h0);
`endif
    cycle();
    idle();
    expect_v("post13_rd1", K_RD1, 32'h5);
    expect_v("post13_b1",  K_B1,  32'h1);
    expect_v("post13_bv",  K_BV,  32'h0000_2200);
    cycle();

    // Independent lanes to different addresses, read on both ports
    bus.we1 = 1'b1; bus.wa1 = 5'd20; bus.wd1 = 32'h1234;
    bus.we2 = 1'b1; bus.wa2 = 5'd21; bus.wd2 = 32'h5678;
    cycle();
    idle();
    bus.ra1 = 5'd20;
    bus.ra2 = 5'd21;
    expect_v("dual_rd1", K_RD1, 32'h1234);
    expect_v("dual_rd2", K_RD2, 32'h5678);
    cycle();

    // Mid-sequence reset discards busy state and data
    rst = 1'b1;
    cycle();
    idle();
    bus.ra1 = 5'd9;
    bus.ra2 = 5'd21;
    expect_v("rst2_rd1", K_RD1, 32'h0);
    expect_v("rst2_b1",  K_B1,  32'h0);
    expect_v("rst2_rd2", K_RD2, 32'h0);
    expect_v("rst2_bv",  K_BV,  32'h0);
    cycle();

    // The monitor drains the queue on every falling edge; anything left is a lost check.
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file with two combinational read ports, two synchronous write ports and a per-register busy scoreboard.
- Used by the pipelined core.
- The issue stage marks a destination register busy. Writeback (two retire lanes) writes data and clears busy.
- Decode reads operands and busy flags in the same cycle to decide stalls.

Parameters:
XLEN, 32, data width of each register in bits
AW, 5, address width; register count NREG = 2**AW
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
ra1  input  AW  read address, port 1
ra2  input  AW  read address, port 2
rd1  output  XLEN  read data, port 1 (combinational)
rd2  output  XLEN  read data, port 2 (combinational)
rd1_busy  output  1  busy flag of ra1 (combinational)
rd2_busy  output  1  busy flag of ra2 (combinational)
we1  input  1  write enable, lane 1
wa1  input  AW  write address, lane 1
wd1  input  XLEN  write data, lane 1
we2  input  1  write enable, lane 2
wa2  input  AW  write address, lane 2
wd2  input  XLEN  write data, lane 2
iss_en  input  1  issue strobe: mark iss_addr busy
iss_addr  input  AW  destination register being issued
busy_vec  output  NREG  registered busy bits, bit i = register i

Behaviour:
- One clock (clk), synchronous active-high reset (rst).
- Reset: on a rising edge with rst=1, every register becomes 0 and every busy bit becomes 0.
  - Reset overrides all writes and issues in that cycle.
  - After reset: rd1=rd2=0, rd1_busy=rd2_busy=0, busy_vec=0.
  - Reset asserted mid-sequence discards any pending busy state.
- Reads: combinational, zero latency from ra1/ra2 to rd1/rd2. Without the optional feature, reads return the pre-edge register contents.
- Writes: on the rising edge, lane k with wek=1 stores wdk into REG[wak].
  - wa1==wa2 with both enabled: lane 2 wins for data.
  - Both lanes clear busy for their address.
- Issue: on the rising edge, iss_en=1 sets busy[iss_addr].
- Same-edge priority for busy: set beats clear. An issue to an address that is also written in the same cycle leaves busy=1, because the issue belongs to a younger instruction.
- Issue to an address already busy: busy stays 1; no error.
- Write to a non-busy address: data written, busy stays 0.
- Register 0 with ZERO_REG=1:
  - writes ignored, issues ignored;
  - rd1/rd2 = 0 and rd*_busy = 0 whenever the read address is 0;
  - busy_vec[0] always 0.
- rdN_busy = busy_vec[raN], subject to the bypass rules below.
- No internal FSM beyond the NREG-entry data array and the busy bit vector. All state changes are edge-triggered; no latches.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If raN matches an enabled write lane's address (and is not register 0 with ZERO_REG=1), rdN returns that lane's data in the same cycle, lane 2 taking priority over lane 1.
  - rdN_busy is forced to 0 for that address unless iss_en=1 with iss_addr==raN in the same cycle.
  - busy_vec is unaffected: it stays registered.
- Undefined: no forwarding. rdN/rdN_busy reflect the stored state only, and written data becomes visible the cycle after the edge.

Test Plan:
- Reset, then ra1=3, ra2=31 -> rd1=rd2=0, busy_vec=0. Next, with rst=1 and we1=1 wa1=3 wd1=0xAAAA5555 on the same edge -> REG[3] stays 0.
- we1=1 wa1=5 wd1=0x11, we2=1 wa2=5 wd2=0x22 on the same edge; then ra1=5 -> rd1=0x22 (lane 2 wins).
- iss_en=1 iss_addr=7 -> busy_vec[7]=1, rd1_busy=1 at ra1=7. Next cycle we1=1 wa1=7 wd1=0x99 -> busy_vec[7]=0, rd1=0x99.
- Same edge: iss_en=1 iss_addr=9 and we2=1 wa2=9 wd2=0x44 -> REG[9]=0x44 and busy_vec[9]=1 (issue wins).
- ZERO_REG=1: iss_en=1 iss_addr=0 plus we1=1 wa1=0 wd1=0xFFFFFFFF -> rd1 at ra1=0 is 0, rd1_busy=0, busy_vec[0]=0.
- With REGFILE_BYPASS_EN: busy_vec[12]=1, then in one cycle we1=1 wa1=12 wd1=0xCAFE and ra2=12 -> rd2=0xCAFE and rd2_busy=0 before the edge. Without the macro -> rd2=old value and rd2_busy=1 until after the edge.
